// File: rtl/axil2iob.sv
// AXI-Lite slave to IOb master bridge: one-entry AW/W/AR holding buffers feeding a
// single-outstanding IOb request FSM with round-robin write/read arbitration.
module axil2iob #(
    parameter int AXIL_ADDR_W = 32,
    parameter int AXIL_DATA_W = 32,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     arst_i,
    input  logic                     axil_awvalid_i,
    output logic                     axil_awready_o,
    input  logic [AXIL_ADDR_W-1:0]   axil_awaddr_i,
    input  logic [2:0]               axil_awprot_i,
    input  logic                     axil_wvalid_i,
    output logic                     axil_wready_o,
    input  logic [AXIL_DATA_W-1:0]   axil_wdata_i,
    input  logic [AXIL_DATA_W/8-1:0] axil_wstrb_i,
    output logic                     axil_bvalid_o,
    input  logic                     axil_bready_i,
    output logic [1:0]               axil_bresp_o,
    input  logic                     axil_arvalid_i,
    output logic                     axil_arready_o,
    input  logic [AXIL_ADDR_W-1:0]   axil_araddr_i,
    input  logic [2:0]               axil_arprot_i,
    output logic                     axil_rvalid_o,
    input  logic                     axil_rready_i,
    output logic [AXIL_DATA_W-1:0]   axil_rdata_o,
    output logic [1:0]               axil_rresp_o,
    output logic                     iob_avalid_o,
    output logic [ADDR_W-1:0]        iob_addr_o,
    output logic [DATA_W-1:0]        iob_wdata_o,
    output logic [DATA_W/8-1:0]      iob_wstrb_o,
    input  logic                     iob_ready_i,
    input  logic                     iob_rvalid_i,
    input  logic [DATA_W-1:0]        iob_rdata_i
);

    localparam int MAP_W = (ADDR_W < AXIL_ADDR_W) ? ADDR_W : AXIL_ADDR_W;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP} state_t;

    state_t state, next_state;

    logic                   aw_held, w_held, ar_held, last_wr;
    logic [AXIL_ADDR_W-1:0] aw_addr, ar_addr;
    logic [DATA_W-1:0]      w_data, rdata_q;
    logic [DATA_W/8-1:0]    w_strb;
    logic [ADDR_W-1:0]      aw_map, ar_map;

    logic aw_hs, w_hs, ar_hs;
    logic clr_wr, clr_rd, set_last_wr, clr_last_wr, cap_rdata;
    logic wr_rdy, rd_rdy, pick_wr;

    logic unused;
    assign unused = ^{axil_awprot_i, axil_arprot_i};

    // Ready depends only on the holding flags (and reset), never on any valid input.
    assign axil_awready_o = !aw_held && !arst_i;
    assign axil_wready_o  = !w_held  && !arst_i;
    assign axil_arready_o = !ar_held && !arst_i;

    assign aw_hs = axil_awvalid_i && axil_awready_o;
    assign w_hs  = axil_wvalid_i  && axil_wready_o;
    assign ar_hs = axil_arvalid_i && axil_arready_o;

    always_comb begin
        aw_map = '0;
        ar_map = '0;
        aw_map[MAP_W-1:0] = aw_addr[MAP_W-1:0];
        ar_map[MAP_W-1:0] = ar_addr[MAP_W-1:0];
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
        end else if (cke_i) begin
            state <= next_state;
        end
    end

    assign wr_rdy  = aw_held && w_held;
    assign rd_rdy  = ar_held;
    assign pick_wr = wr_rdy && (!rd_rdy || !last_wr);

    always_comb begin
        next_state  = state;
        clr_wr      = 1'b0;
        clr_rd      = 1'b0;
        set_last_wr = 1'b0;
        clr_last_wr = 1'b0;
        cap_rdata   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_wr) begin
                    // All-zero strobe: nothing to write, answer the master directly.
                    if (w_strb == '0) begin
                        next_state = WR_RESP;
                        clr_wr     = 1'b1;
                    end else begin
                        next_state = WR_REQ;
                    end
                end else if (rd_rdy) begin
                    next_state = RD_REQ;
                end
            end
            WR_REQ: begin
                if (iob_ready_i) begin
                    next_state  = WR_RESP;
                    clr_wr      = 1'b1;
                    set_last_wr = 1'b1;
                end
            end
            WR_RESP: begin
                if (axil_bready_i) next_state = IDLE;
            end
            RD_REQ: begin
                if (iob_ready_i) begin
                    next_state  = RD_WAIT;
                    clr_rd      = 1'b1;
                    clr_last_wr = 1'b1;
                end
            end
            RD_WAIT: begin
                if (iob_rvalid_i) begin
                    next_state = RD_RESP;
                    cap_rdata  = 1'b1;
                end
            end
            RD_RESP: begin
                if (axil_rready_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        iob_avalid_o  = 1'b0;
        iob_addr_o    = '0;
        iob_wdata_o   = '0;
        iob_wstrb_o   = '0;
        axil_bvalid_o = 1'b0;
        axil_rvalid_o = 1'b0;
        case (state)
            WR_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = aw_map;
                iob_wdata_o  = w_data;
                iob_wstrb_o  = w_strb;
            end
            RD_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = ar_map;
            end
            WR_RESP: axil_bvalid_o = 1'b1;
            RD_RESP: axil_rvalid_o = 1'b1;
            default: ;
        endcase
    end

    assign axil_bresp_o = '0;
    assign axil_rresp_o = '0;
    assign axil_rdata_o = rdata_q;

    // Capture and clear never coincide: capture needs the flag low, clear needs it high.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            ar_held <= 1'b0;
            last_wr <= 1'b0;
            aw_addr <= '0;
            ar_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            rdata_q <= '0;
        end else if (cke_i) begin
            if (aw_hs) begin
                aw_addr <= axil_awaddr_i;
                aw_held <= 1'b1;
            end else if (clr_wr) begin
                aw_held <= 1'b0;
            end
            if (w_hs) begin
                w_data <= axil_wdata_i;
                w_strb <= axil_wstrb_i;
                w_held <= 1'b1;
            end else if (clr_wr) begin
                w_held <= 1'b0;
            end
            if (ar_hs) begin
                ar_addr <= axil_araddr_i;
                ar_held <= 1'b1;
            end else if (clr_rd) begin
                ar_held <= 1'b0;
            end
            if (set_last_wr) begin
                last_wr <= 1'b1;
            end else if (clr_last_wr) begin
                last_wr <= 1'b0;
            end
            if (cap_rdata) rdata_q <= iob_rdata_i;
        end
    end

endmodule
